dmem_responder: RTL

- Data-memory responder: the slave end of the memory-stage data-memory interface. Accepts one command per cycle (address, command, write data) and returns load data.
- Word-organised synchronous array with a fixed-latency read-response pipeline and misalignment detection.
- Sits between the pipeline's memory stage and the rest of the processor top. Its mem_dout drives the memory stage's DM_mem_dout input.

---
 rtl/dmem_responder_pkg.sv | 15 +
 rtl/dmem_responder_if.sv | 21 ++
 rtl/dmem_resp_pipe.sv | 26 ++
 rtl/dmem_responder.sv | 77 +++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared command encodings and the response record used by the data-memory responder.
package dmem_responder_pkg;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_LOAD  = 2'b01;
    localparam logic [1:0] MEM_STORE = 2'b10;
    localparam logic [1:0] MEM_RSVD  = 2'b11;

    typedef struct packed {
        logic        vld;
        logic        misalign;
        logic [31:0] data;
    } dmem_resp_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Memory-stage <-> data-memory request/response bundle.
interface dmem_responder_if;

    logic [31:0] mem_addr;
    logic [1:0]  mem_cmd;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic        mem_dout_vld;
    logic        mem_misalign;

    modport master (
        output mem_addr, mem_cmd, mem_din,
        input  mem_dout, mem_dout_vld, mem_misalign
    );

    modport slave (
        input  mem_addr, mem_cmd, mem_din,
        output mem_dout, mem_dout_vld, mem_misalign
    );

endinterface

// File: rtl/dmem_resp_pipe.sv
// Fixed-latency shift register of response records; reset discards everything in flight.
module dmem_resp_pipe
    import dmem_responder_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  dmem_resp_t resp_in,
    output dmem_resp_t resp_out
);

    dmem_resp_t stage [LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) stage[i] <= '0;
        end else begin
            stage[0] <= resp_in;
            for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
        end
    end

    assign resp_out = stage[LATENCY-1];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word array, command decode, saturating counters and
// a fixed-latency load-response path.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic              clk,
    input  logic              rst,
    dmem_responder_if.slave   bus,
    output logic [15:0]       load_cnt,
    output logic [15:0]       store_cnt
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [31:0]      mem [DEPTH_WORDS];
    logic [IDX_W-1:0] idx;
    logic             aligned;
    logic             is_load;
    logic             is_store;
    logic             load_ok;
    logic             store_ok;
    logic [31:0]      dout_hold;
    logic             unused_addr_hi;
    dmem_resp_t       resp_in;
    dmem_resp_t       resp_out;

    // Upper address bits alias onto the array so addresses wrap.
    assign idx            = bus.mem_addr[IDX_W+1:2];
    assign unused_addr_hi = ^bus.mem_addr[31:IDX_W+2];
    assign aligned        = (bus.mem_addr[1:0] == 2'b00);
    assign is_load        = (bus.mem_cmd == MEM_LOAD);
    assign is_store       = (bus.mem_cmd == MEM_STORE);
    assign load_ok        = is_load && aligned;
    assign store_ok       = is_store && aligned;

    always_ff @(posedge clk) begin
        if (store_ok) mem[idx] <= bus.mem_din;
    end

    always_comb begin
        resp_in          = '0;
        resp_in.vld      = load_ok;
        resp_in.misalign = (is_load || is_store) && !aligned;
        resp_in.data     = load_ok ? mem[idx] : 32'h0;
    end

    dmem_resp_pipe #(
        .LATENCY (LATENCY)
    ) u_pipe (
        .clk      (clk),
        .rst      (rst),
        .resp_in  (resp_in),
        .resp_out (resp_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_cnt  <= 16'h0;
            store_cnt <= 16'h0;
            dout_hold <= 32'h0;
        end else begin
            if (load_ok && load_cnt != 16'hFFFF)   load_cnt  <= load_cnt + 16'd1;
            if (store_ok && store_cnt != 16'hFFFF) store_cnt <= store_cnt + 16'd1;
            if (resp_out.vld) dout_hold <= resp_out.data;
        end
    end

    // Response data is presented in the same cycle as its valid; the hold
    // register only supplies the value between responses.
    assign bus.mem_dout     = resp_out.vld ? resp_out.data : dout_hold;
    assign bus.mem_dout_vld = resp_out.vld;
    assign bus.mem_misalign = resp_out.misalign;

endmodule
